// File: rtl/cpu_bus_arbiter.sv
// Two-master memory bus arbiter: instruction port and data port share one
// memory bus. One transaction at a time, latched on grant and always run to
// completion. Grants alternate when both ports keep requesting.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; arbitrate among the ports raising start
// I_BUSY | instruction port owns the bus; wait for mem_done
// D_BUSY | data port owns the bus; wait for mem_done
module cpu_bus_arbiter #(
  parameter bit DATA_FIRST = 1'b1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_data,
  input  logic              i_we,
  input  logic              i_start,
  output logic [31:0]       i_q,
  output logic              i_done,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_data,
  input  logic              d_we,
  input  logic              d_start,
  output logic [31:0]       d_q,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_we,
  output logic              mem_start,
  input  logic [31:0]       mem_q,
  input  logic              mem_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;
  // Set until the first grant after reset, so a tie then follows DATA_FIRST
  // instead of the alternation history.
  logic              fresh, fresh_nxt;
  logic [ADDR_W-1:0] addr_lat, addr_nxt;
  logic [31:0]       data_lat, data_nxt;
  logic              we_lat, we_nxt;
  logic              pick_d;
  logic              busy;

  // State, grant history and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      fresh      <= 1'b1;
      addr_lat   <= '0;
      data_lat   <= '0;
      we_lat     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      fresh      <= fresh_nxt;
      addr_lat   <= addr_nxt;
      data_lat   <= data_nxt;
      we_lat     <= we_nxt;
    end
  end

  // Arbitration in IDLE; busy states only wait for the memory completion.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    fresh_nxt      = fresh;
    addr_nxt       = addr_lat;
    data_nxt       = data_lat;
    we_nxt         = we_lat;
    pick_d         = 1'b0;
    case (state)
      IDLE: begin
        if (i_start || d_start) begin
          if (i_start && d_start) begin
            pick_d = fresh ? DATA_FIRST : !last_grant;
          end else begin
            pick_d = d_start;
          end
          fresh_nxt      = 1'b0;
          last_grant_nxt = pick_d;
          if (pick_d) begin
            state_nxt = D_BUSY;
            addr_nxt  = d_addr;
            data_nxt  = d_data;
            we_nxt    = d_we;
          end else begin
            state_nxt = I_BUSY;
            addr_nxt  = i_addr;
            data_nxt  = i_data;
            we_nxt    = i_we;
          end
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == I_BUSY) || (state == D_BUSY);
  assign mem_start = busy && !mem_done;
  assign mem_addr  = addr_lat;
  assign mem_data  = data_lat;
  assign mem_we    = we_lat;

  // Completion is steered only to the owner; a done seen in IDLE goes nowhere.
  assign i_done = mem_done && (state == I_BUSY);
  assign d_done = mem_done && (state == D_BUSY);
  assign i_q    = i_done ? mem_q : 32'd0;
  assign d_q    = d_done ? mem_q : 32'd0;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed stimulus pushes expected grants and
// completions into queues; a monitor pops and compares them as the DUT shows
// mem_start rising or a done pulse.
module tb_cpu_bus_arbiter;
  localparam int ADDR_W = 32;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
  logic [31:0]       i_data, d_data, mem_data;
  logic              i_we, d_we, mem_we;
  logic              i_start, d_start, mem_start;
  logic [31:0]       i_q, d_q, mem_q;
  logic              i_done, d_done, mem_done;

  logic              mem_auto;
  logic              force_done;
  logic [31:0]       force_q;
  logic              auto_done;
  logic [31:0]       auto_q;
  int                rsp_cnt;
  int                rsp_idx;
  logic [31:0]       rsp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } grant_t;

  typedef struct {
    bit          is_d;
    logic [31:0] q;
  } done_t;

  grant_t grant_q[$];
  done_t  done_q[$];

  int total = 0;
  int bad   = 0;

  cpu_bus_arbiter #(.DATA_FIRST(1'b1), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_we      (i_we),
    .i_start   (i_start),
    .i_q       (i_q),
    .i_done    (i_done),
    .d_addr    (d_addr),
    .d_data    (d_data),
    .d_we      (d_we),
    .d_start   (d_start),
    .d_q       (d_q),
    .d_done    (d_done),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .mem_start (mem_start),
    .mem_q     (mem_q),
    .mem_done  (mem_done)
  );

  always #5 clk = ~clk;

  assign mem_done = mem_auto ? auto_done : force_done;
  assign mem_q    = mem_auto ? auto_q    : force_q;

  // Memory model: completes LAT cycles into each transaction with the next
  // queued read value.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      auto_done = 1'b0;
      rsp_cnt   = 0;
    end else if (auto_done) begin
      auto_done = 1'b0;
      rsp_cnt   = 0;
    end else if (mem_auto && mem_start) begin
      rsp_cnt = rsp_cnt + 1;
      if (rsp_cnt >= LAT) begin
        auto_done = 1'b1;
        if (rsp_idx < rsp_q.size()) begin
          auto_q  = rsp_q[rsp_idx];
          rsp_idx = rsp_idx + 1;
        end else begin
          auto_q = 32'hA5A5_A5A5;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_txn(input bit is_d, input logic [31:0] addr, input logic we,
                          input logic [31:0] data, input logic [31:0] rdata);
    grant_t g;
    done_t  e;
    g.addr = addr; g.we = we; g.data = data;
    e.is_d = is_d; e.q = rdata;
    grant_q.push_back(g);
    done_q.push_back(e);
    rsp_q.push_back(rdata);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (done_q.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s: timeout with %0d completions outstanding, want 0", name, done_q.size());
      done_q.delete();
      grant_q.delete();
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_start"}, mem_start, 0);
    chk({tag, "_mem_we"},    mem_we,    0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_data"},  mem_data,  0);
    chk({tag, "_i_done"},    i_done,    0);
    chk({tag, "_i_q"},       i_q,       0);
    chk({tag, "_d_done"},    d_done,    0);
    chk({tag, "_d_q"},       d_q,       0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i_start = 1'b0;
    d_start = 1'b0;
    step();
    step();
    chk_outputs_zero("reset");
    reset = 1'b0;
  endtask

  task automatic monitor();
    int   cyc       = 0;
    int   last_done = 0;
    bit   have_done = 0;
    logic prev_start = 1'b0;
    grant_t g;
    done_t  e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_start && !prev_start) begin
        if (have_done) chk("idle_gap", ((cyc - last_done) >= 2), 1);
        if (grant_q.size() == 0) begin
          total = total + 1;
          bad   = bad + 1;
          $display("FAIL grant: unexpected grant addr=%h, want none", mem_addr);
        end else begin
          g = grant_q.pop_front();
          chk("grant_addr", mem_addr, g.addr);
          chk("grant_we",   mem_we,   g.we);
          chk("grant_data", mem_data, g.data);
        end
      end
      prev_start = mem_start;
      if (i_done || d_done) begin
        chk("one_done", (i_done && d_done), 0);
        if (done_q.size() == 0) begin
          total = total + 1;
          bad   = bad + 1;
          $display("FAIL done: unexpected i_done=%b d_done=%b, want none", i_done, d_done);
        end else begin
          e = done_q.pop_front();
          chk("done_port", d_done, e.is_d);
          chk("done_q", e.is_d ? d_q : i_q, e.q);
        end
        last_done = cyc;
        have_done = 1;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    i_addr     = '0; i_data = '0; i_we = 1'b0; i_start = 1'b0;
    d_addr     = '0; d_data = '0; d_we = 1'b0; d_start = 1'b0;
    mem_auto   = 1'b1;
    force_done = 1'b0;
    force_q    = '0;
    auto_done  = 1'b0;
    auto_q     = '0;
    rsp_cnt    = 0;
    rsp_idx    = 0;

    fork
      monitor();
    join_none

    do_reset();

    // single instruction read, one-cycle grant latency
    i_addr = 32'h100; i_data = 32'h0; i_we = 1'b0; i_start = 1'b1;
    push_txn(1'b0, 32'h100, 1'b0, 32'h0, 32'hDEAD_BEEF);
    chk("t1_pre_start", mem_start, 0);
    step();
    chk("t1_start_lat", mem_start, 1);
    wait_done("t1_wait", 40);
    i_start = 1'b0;

    // single data write so last_grant=1 before the next reset
    d_addr = 32'h280; d_data = 32'h99; d_we = 1'b1; d_start = 1'b1;
    push_txn(1'b1, 32'h280, 1'b1, 32'h99, 32'h1111_1111);
    wait_done("t1b_wait", 40);
    d_start = 1'b0;

    // simultaneous after reset: data first, then instruction
    do_reset();
    i_addr = 32'h300; i_data = 32'h0;  i_we = 1'b0; i_start = 1'b1;
    d_addr = 32'h200; d_data = 32'h55; d_we = 1'b1; d_start = 1'b1;
    push_txn(1'b1, 32'h200, 1'b1, 32'h55, 32'hD000_0001);
    push_txn(1'b0, 32'h300, 1'b0, 32'h0,  32'h1000_0002);
    wait_done("t2_wait", 80);
    i_start = 1'b0; d_start = 1'b0;
    step();

    // alternation with both held: D, I, D, I
    i_start = 1'b1; d_start = 1'b1;
    push_txn(1'b1, 32'h200, 1'b1, 32'h55, 32'h0000_D001);
    push_txn(1'b0, 32'h300, 1'b0, 32'h0,  32'h0000_1002);
    push_txn(1'b1, 32'h200, 1'b1, 32'h55, 32'h0000_D003);
    push_txn(1'b0, 32'h300, 1'b0, 32'h0,  32'h0000_1004);
    wait_done("t3_wait", 160);
    i_start = 1'b0; d_start = 1'b0; d_we = 1'b0;
    step();

    // instruction withdraws start mid-transaction; transfer still completes
    i_addr = 32'h400; i_start = 1'b1;
    push_txn(1'b0, 32'h400, 1'b0, 32'h0, 32'h4444_0000);
    step();
    step();
    i_start = 1'b0;
    chk("t4_hold_start", mem_start, 1);
    wait_done("t4_wait", 40);
    step();

    // stray done in IDLE
    mem_auto   = 1'b0;
    force_q    = 32'hCAFE_F00D;
    force_done = 1'b1;
    #1;
    chk("t6_i_done", i_done, 0);
    chk("t6_d_done", d_done, 0);
    chk("t6_i_q",    i_q,    0);
    chk("t6_d_q",    d_q,    0);
    step();
    force_done = 1'b0;
    step();
    chk("t6_idle", mem_start, 0);

    // reset while D_BUSY, then a late done
    d_addr = 32'h500; d_data = 32'h77; d_we = 1'b1; d_start = 1'b1;
    grant_q.push_back('{addr: 32'h500, we: 1'b1, data: 32'h77});
    step();
    step();
    chk("t5_busy", mem_start, 1);
    reset = 1'b1; d_start = 1'b0; d_we = 1'b0;
    step();
    chk_outputs_zero("t5_in_reset");
    reset = 1'b0;
    step();
    force_q    = 32'h1234_5678;
    force_done = 1'b1;
    #1;
    chk("t5_late_d_done", d_done, 0);
    chk("t5_late_i_done", i_done, 0);
    chk("t5_late_d_q",    d_q,    0);
    chk("t5_late_start",  mem_start, 0);
    step();
    force_done = 1'b0;
    step();
    chk("t5_idle", mem_start, 0);
    chk("t5_addr", mem_addr, 0);

    repeat (3) step();
    chk("left_grants", grant_q.size(), 0);
    chk("left_dones",  done_q.size(),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
